// File: rtl/taxi_ride_ctrl.sv
// Ride sequencer for the taxi meter: ride state machine, stepper drive and fare strobes.
// Latency: every output is registered; a state change shows 1 cycle after the inputs are sampled.
// Backpressure: none; strobes are single-cycle pulses and the downstream counters must take them as they come.
//
// Ports:
//   clk_M      system clock
//   reset      async active-high, clears all state
//   start      1 = ride active, 0 forces IDLE
//   pause      freeze the ride
//   waitL      waiting at a light, accrue wait time
//   speedup    step rate multiplier 2^speedup
//   Dir        0 = forward phase order, 1 = reverse
//   StepDrive  stepper coil drive
//   state      0 IDLE, 1 RUN, 2 PAUSE, 3 WAIT
//   meter_en   high whenever the ride is not IDLE
//   new_ride   1-cycle pulse on IDLE->RUN
//   dist_tick  1-cycle pulse per distance unit
//   wait_tick  1-cycle pulse per wait unit
//
// Build option: define TAXI_CTRL_HALFSTEP_EN for the 8-phase half-step sequence.
// In that build a distance unit is twice as many (half-)steps, so the distance per tick is unchanged.

module taxi_ride_ctrl #(
  parameter int STEP_DIV_BASE  = 50000,
  parameter int STEPS_PER_UNIT = 200,
  parameter int WAIT_UNIT_CYC  = 25000000
) (
  input  logic       clk_M,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       waitL,
  input  logic [1:0] speedup,
  input  logic       Dir,
  output logic [3:0] StepDrive,
  output logic [1:0] state,
  output logic       meter_en,
  output logic       new_ride,
  output logic       dist_tick,
  output logic       wait_tick
);

`ifdef TAXI_CTRL_HALFSTEP_EN
  localparam int PH_W       = 3;
  localparam int UNIT_STEPS = 2 * STEPS_PER_UNIT;
`else
  localparam int PH_W       = 2;
  localparam int UNIT_STEPS = STEPS_PER_UNIT;
`endif
  localparam int PRE_W = $clog2(STEP_DIV_BASE + 1);
  localparam int STP_W = $clog2(UNIT_STEPS + 1);
  localparam int WT_W  = $clog2(WAIT_UNIT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t            cur_st, nxt_st;
  logic [PRE_W-1:0]  pre_q, pre_nxt;
  logic [STP_W-1:0]  stp_q, stp_nxt;
  logic [WT_W-1:0]   wt_q, wt_nxt;
  logic [PH_W-1:0]   ph_q, ph_nxt;
  logic              dist_nxt, wait_nxt;
  logic [PRE_W-1:0]  limit_m1;

  // Phase index to coil pattern.
  function automatic logic [3:0] phase_drive(input logic [PH_W-1:0] idx);
    logic [3:0] d;
`ifdef TAXI_CTRL_HALFSTEP_EN
    case (idx)
      3'd0:    d = 4'b0001;
      3'd1:    d = 4'b0011;
      3'd2:    d = 4'b0010;
      3'd3:    d = 4'b0110;
      3'd4:    d = 4'b0100;
      3'd5:    d = 4'b1100;
      3'd6:    d = 4'b1000;
      default: d = 4'b1001;
    endcase
`else
    case (idx)
      2'd0:    d = 4'b0001;
      2'd1:    d = 4'b0010;
      2'd2:    d = 4'b0100;
      default: d = 4'b1000;
    endcase
`endif
    return d;
  endfunction

  // Last prescaler value of a step period at the current speed.
  assign limit_m1 = PRE_W'((STEP_DIV_BASE >> speedup) - 1);

  // Next-state logic; start low overrides everything.
  always_comb begin
    nxt_st = cur_st;
    if (!start) begin
      nxt_st = S_IDLE;
    end else begin
      case (cur_st)
        S_IDLE:  nxt_st = S_RUN;
        S_RUN: begin
          if (pause)      nxt_st = S_PAUSE;
          else if (waitL) nxt_st = S_WAIT;
        end
        S_PAUSE: begin
          if (!pause)     nxt_st = waitL ? S_WAIT : S_RUN;
        end
        S_WAIT: begin
          if (pause)      nxt_st = S_PAUSE;
          else if (!waitL) nxt_st = S_RUN;
        end
        default: nxt_st = S_IDLE;
      endcase
    end
  end

  // Counters advance according to the state currently held. Dropping start
  // clears them on the same edge so the IDLE cycle already shows a clean ride
  // and no strobe leaks out of an aborted ride. Phase index survives IDLE so
  // the motor resumes from the coil it stopped on.
  always_comb begin
    pre_nxt  = pre_q;
    stp_nxt  = stp_q;
    wt_nxt   = wt_q;
    ph_nxt   = ph_q;
    dist_nxt = 1'b0;
    wait_nxt = 1'b0;
    if (!start || cur_st == S_IDLE) begin
      pre_nxt = '0;
      stp_nxt = '0;
      wt_nxt  = '0;
    end else if (cur_st == S_RUN) begin
      // >= rather than == so a speed increase mid-count steps at once.
      if (pre_q >= limit_m1) begin
        pre_nxt = '0;
        ph_nxt  = Dir ? ph_q - PH_W'(1) : ph_q + PH_W'(1);
        if (stp_q >= STP_W'(UNIT_STEPS - 1)) begin
          stp_nxt  = '0;
          dist_nxt = 1'b1;
        end else begin
          stp_nxt = stp_q + STP_W'(1);
        end
      end else begin
        pre_nxt = pre_q + PRE_W'(1);
      end
    end else if (cur_st == S_WAIT) begin
      if (wt_q >= WT_W'(WAIT_UNIT_CYC - 1)) begin
        wt_nxt   = '0;
        wait_nxt = 1'b1;
      end else begin
        wt_nxt = wt_q + WT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_M or posedge reset) begin
    if (reset) begin
      cur_st    <= S_IDLE;
      pre_q     <= '0;
      stp_q     <= '0;
      wt_q      <= '0;
      ph_q      <= '0;
      StepDrive <= 4'b0000;
      meter_en  <= 1'b0;
      new_ride  <= 1'b0;
      dist_tick <= 1'b0;
      wait_tick <= 1'b0;
    end else begin
      cur_st    <= nxt_st;
      pre_q     <= pre_nxt;
      stp_q     <= stp_nxt;
      wt_q      <= wt_nxt;
      ph_q      <= ph_nxt;
      // Outputs are built from next values so they line up with the state output.
      StepDrive <= (nxt_st == S_RUN) ? phase_drive(ph_nxt) : 4'b0000;
      meter_en  <= (nxt_st != S_IDLE);
      new_ride  <= (cur_st == S_IDLE) && (nxt_st == S_RUN);
      dist_tick <= dist_nxt;
      wait_tick <= wait_nxt;
    end
  end

  assign state = cur_st;

endmodule
